// File: rtl/sda_pkg.sv
// sda_pkg: shared state encoding and default geometry for the sda initiator/responder pair.
package sda_pkg;
    localparam int DATA_W_DEF   = 8;
    localparam int TURN_CYC_DEF = 1;
    typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE} state_e;
endpackage

// File: rtl/sda_shift_reg.sv
// sda_shift_reg: loadable shift register, shifts left (MSB out) or right (serial in at MSB).
module sda_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shl_i,
    input  logic         shr_i,
    input  logic         ser_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] nxt_o
);
    logic [W-1:0] sh_q;
    always_comb nxt_o = load_i ? d_i : shl_i ? {sh_q[W-2:0], 1'b0} : shr_i ? {ser_i, sh_q[W-1:1]} : sh_q;
    always_ff @(posedge clk) begin
        sh_q <= rst ? '0 : nxt_o;
    end
    assign q_o = sh_q;
endmodule

// File: rtl/sda_initiator.sv
// sda_initiator: sends a word MSB-first on sda, turns the line around, captures the LSB-first reply.
// Define SDA_ECHO_CHECK_EN to compare the reply against the sent word (echo_err).
module sda_initiator
    import sda_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              echo_err,
    output logic              oe,
    inout  wire               sda
);
    localparam int CMAX = (DATA_W > TURN_CYC) ? DATA_W : TURN_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LAST_W = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_T = CW'(TURN_CYC - 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              oe_q, busy_q, done_q;
    logic [DATA_W-1:0] rx_data_q, tx_sh, tx_nxt, rx_sh, rx_nxt;
    logic              accept, rx_last, unused_bits;

    assign accept  = (state_q == IDLE) && start;
    assign rx_last = (state_q == RX) && (cnt_q == LAST_W);

    sda_shift_reg #(.W(DATA_W)) u_tx (
        .clk(clk), .rst(rst), .load_i(accept), .shl_i(state_q == TX), .shr_i(1'b0),
        .ser_i(1'b0), .d_i(tx_data), .q_o(tx_sh), .nxt_o(tx_nxt)
    );
    sda_shift_reg #(.W(DATA_W)) u_rx (
        .clk(clk), .rst(rst), .load_i(1'b0), .shl_i(1'b0), .shr_i(state_q == RX),
        .ser_i(sda), .d_i('0), .q_o(rx_sh), .nxt_o(rx_nxt)
    );
    assign unused_bits = ^{tx_sh[DATA_W-2:0], tx_nxt, rx_sh};

    // done/rx_data rise together on the last sample edge so the word is valid during the pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= TX;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                TX: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_W) begin
                        state_q <= TURN;
                        cnt_q   <= '0;
                        oe_q    <= 1'b1;
                    end
                end
                TURN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_T) begin
                        state_q <= RX;
                        cnt_q   <= '0;
                    end
                end
                RX: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (rx_last) begin
                        state_q   <= DONE;
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_nxt;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SDA_ECHO_CHECK_EN
    logic [DATA_W-1:0] tx_copy_q;
    logic              echo_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_copy_q  <= '0;
            echo_err_q <= 1'b0;
        end else begin
            if (accept) tx_copy_q <= tx_data;
            if (rx_last) echo_err_q <= (rx_nxt != tx_copy_q);
        end
    end
    assign echo_err = echo_err_q;
`else
    assign echo_err = 1'b0;
`endif

    assign sda     = oe_q ? 1'bz : tx_sh[DATA_W-1];
    assign oe      = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
endmodule

// File: tb/tb_sda_initiator.sv
// tb_sda_initiator: sda_initiator against an echoing responder, checked every cycle by a transfer-timeline model.
module tb_sda_initiator;
    import sda_pkg::*;
    localparam int W   = DATA_W_DEF;
    localparam int T   = TURN_CYC_DEF;
    localparam int LAT = 2 * W + T + 1;
    localparam int RX0 = W + T + 1;
`ifdef SDA_ECHO_CHECK_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, force_one = 1'b0;
    logic [W-1:0] tx_data = '0, rx_data;
    logic busy, done, echo_err, oe;
    wire  sda;

    sda_initiator #(.DATA_W(W), .TURN_CYC(T)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
        .rx_data(rx_data), .echo_err(echo_err), .oe(oe), .sda(sda)
    );

    always #5 clk = ~clk;

    // echo responder: collects bits while the initiator drives, replays them LSB-first after the turn
    logic [W-1:0] rsp  = '0;
    int           rcnt = 0;
    assign sda = (oe && force_one) ? 1'b1 : (oe && rcnt >= 1 && rcnt <= W) ? rsp[rcnt-1] : 1'bz;
    always @(posedge clk) begin
        if (!oe) begin
            rsp  <= {rsp[W-2:0], sda};
            rcnt <= 0;
        end else rcnt <= rcnt + 1;
    end

    int t = 0;
    logic [W-1:0] word = '0, exp_rx = '0, mrx = '0, seq;
    logic exp_err = 1'b0;
    int checks = 0, failures = 0, lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic compare();
        chk("busy", busy, 32'(t > 0));
        chk("done", done, 32'(t == LAT));
        chk("oe", oe, 32'(t >= W + 1));
        chk("rx_data", rx_data, exp_rx);
        chk("echo_err", echo_err, exp_err);
        if (t == 0) chk("sda_idle", sda, 0);
        else if (t <= W) chk("sda_tx", sda, word[W-t]);
    endtask

    task automatic step(input logic s, input logic [W-1:0] d, input logic r, input logic f);
        start = s; tx_data = d; rst = r; force_one = f;
        if (r) begin
            t = 0; exp_rx = '0; exp_err = 1'b0;
        end else if (t == 0) begin
            if (s) begin t = 1; word = d; end
        end else if (t == LAT) t = 0;
        else begin
            if (t >= RX0 && t < LAT) mrx[t-RX0] = f ? 1'b1 : word[t-RX0];
            t++;
            if (t == LAT) begin exp_rx = mrx; exp_err = ECHO && (mrx != word); end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic xfer(input logic [W-1:0] w, input bit hold, input bit frc);
        int n;
        step(1'b1, w, 1'b0, 1'b0);
        n = 1; lat = 0;
        while (t != 0 && n < 64) begin
            if (t <= W) seq[W-t] = sda;
            if (done === 1'b1) lat = n;
            step(hold, hold ? W'($urandom) : w, 1'b0, frc);
            n++;
        end
    endtask

    initial begin
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("reset_rx", rx_data, 0);
        xfer(8'h9D, 1'b0, 1'b0);
        chk("latency", lat, 18);
        chk("sda_seq", seq, 8'b10011101);
        chk("rx_9d", rx_data, 8'h9D);
        chk("err_9d", echo_err, 0);
        xfer(8'hA5, 1'b0, 1'b0);
        chk("rx_a5", rx_data, 8'hA5);
        xfer(8'h3C, 1'b0, 1'b0);
        chk("rx_3c", rx_data, 8'h3C);
        xfer(8'h66, 1'b1, 1'b0);
        chk("rx_held_start", rx_data, 8'h66);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        while (t != RX0 + 2) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("rst_oe", oe, 0);
        chk("rst_rx", rx_data, 0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        xfer(8'h5A, 1'b0, 1'b0);
        chk("rx_5a", rx_data, 8'h5A);
        xfer(8'h0F, 1'b0, 1'b1);
        chk("rx_forced", rx_data, 8'hFF);
        chk("err_forced", echo_err, 32'(ECHO));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                step(1'b1, W'($urandom), 1'b0, 1'b0);
                repeat ($urandom_range(1, LAT - 1)) step(1'($urandom), W'($urandom), 1'b0, 1'b0);
                step(1'b0, '0, 1'b1, 1'b0);
            end else xfer(W'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) step(1'b0, W'($urandom), 1'b0, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
